// File: rtl/mac_tx_pkt_gen.sv
// Test-frame generator for a MAC transmit port: emits bursts of incrementing-byte
// frames with a programmable length, inter-packet gap and frame count.
module mac_tx_pkt_gen #(
  parameter int DATA_W  = 32,
  parameter int BE_W    = 2,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 16
) (
  input  logic              clk_user,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [10:0]       pkt_len,
  input  logic [CNT_W-1:0]  pkt_num,
  input  logic [7:0]        ipg,
  input  logic              tx_mac_wa,
  output logic              tx_mac_wr,
  output logic [DATA_W-1:0] tx_mac_data,
  output logic [BE_W-1:0]   tx_mac_be,
  output logic              tx_mac_sop,
  output logic              tx_mac_eop,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [31:0]       byte_cnt
);
  localparam int BPW = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_next;

  // Burst parameters captured on start
  logic [11:0]      last_q;
  logic [BE_W-1:0]  rem_q;
  logic [CNT_W-1:0] num_q;
  logic [7:0]       ipg_q;

  logic [11:0]      word_idx;
  logic [7:0]       frame_q;
  logic [7:0]       gap_cnt;
  logic             abort_pend;

  logic [10:0]      len_clamp;
  logic [11:0]      len_round;
  logic [11:0]      last_calc;
  logic             xfer;
  logic             is_eop;
  logic             finish;
  logic [CNT_W-1:0] pkt_cnt_inc;
  logic [7:0]       xfer_bytes;
  logic [7:0]       base;
  logic [7:0]       lane;

  always_comb begin
    if (pkt_len > 11'(MAX_LEN))      len_clamp = 11'(MAX_LEN);
    else if (pkt_len < 11'(MIN_LEN)) len_clamp = 11'(MIN_LEN);
    else                             len_clamp = pkt_len;
    len_round = {1'b0, len_clamp} + 12'(BPW - 1);
    last_calc = (len_round >> BE_W) - 12'd1;
  end

  assign is_eop      = (word_idx == last_q);
  assign xfer        = (state == SEND) && tx_mac_wa;
  assign pkt_cnt_inc = pkt_cnt + 1'b1;
  assign xfer_bytes  = is_eop && (rem_q != '0) ? 8'(rem_q) : 8'(BPW);
  // A frame ends the burst on a pending or same-cycle abort, or when the count is met
  assign finish      = abort_pend || abort || ((num_q != '0) && (pkt_cnt_inc == num_q));

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SEND;
      SEND: begin
        if (xfer && is_eop) begin
          if (finish)            state_next = IDLE;
          else if (ipg_q != '0)  state_next = GAP;
          else                   state_next = SEND;
        end
      end
      GAP: begin
        if (abort)              state_next = IDLE;
        else if (gap_cnt == 8'd1) state_next = SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word contents are a pure function of the frame/word position, so they hold
  // naturally while the MAC stalls.
  always_comb begin
    tx_mac_data = '0;
    lane        = '0;
    base        = frame_q + 8'(word_idx << BE_W);
    if (state == SEND) begin
      for (int b = 0; b < BPW; b++) begin
        lane = base + 8'(b);
        if (is_eop && (rem_q != '0) && (b >= int'(rem_q))) lane = '0;
        tx_mac_data[DATA_W-1-8*b -: 8] = lane;
      end
    end
  end

  assign tx_mac_wr  = xfer;
  assign tx_mac_sop = (state == SEND) && (word_idx == '0);
  assign tx_mac_eop = (state == SEND) && is_eop;
  assign tx_mac_be  = tx_mac_eop ? rem_q : '0;
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_user) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      last_q     <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      ipg_q      <= '0;
      word_idx   <= '0;
      frame_q    <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      pkt_cnt    <= '0;
      byte_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_q     <= last_calc;
            rem_q      <= len_clamp[BE_W-1:0];
            num_q      <= pkt_num;
            ipg_q      <= ipg;
            word_idx   <= '0;
            frame_q    <= '0;
            abort_pend <= 1'b0;
            pkt_cnt    <= '0;
            byte_cnt   <= '0;
          end
        end
        SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (xfer) begin
            byte_cnt <= byte_cnt + 32'(xfer_bytes);
            if (is_eop) begin
              word_idx <= '0;
              frame_q  <= frame_q + 8'd1;
              pkt_cnt  <= pkt_cnt_inc;
              gap_cnt  <= ipg_q;
              if (finish) done <= 1'b1;
            end else begin
              word_idx <= word_idx + 12'd1;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (abort) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_pkt_gen.sv
// Self-checking bench for mac_tx_pkt_gen: directed corner cases plus randomized
// bursts compared word-by-word against a frame-level reference model.
module tb_mac_tx_pkt_gen;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 2;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int CNT_W   = 16;
  localparam int BPW     = DATA_W / 8;

  logic              clk_user = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [10:0]       pkt_len = '0;
  logic [CNT_W-1:0]  pkt_num = '0;
  logic [7:0]        ipg = '0;
  logic              tx_mac_wa = 1'b0;
  logic              tx_mac_wr;
  logic [DATA_W-1:0] tx_mac_data;
  logic [BE_W-1:0]   tx_mac_be;
  logic              tx_mac_sop;
  logic              tx_mac_eop;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [31:0]       byte_cnt;

  int n_vec = 0;
  int n_bad = 0;

  mac_tx_pkt_gen #(
    .DATA_W(DATA_W), .BE_W(BE_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk_user   (clk_user),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pkt_len    (pkt_len),
    .pkt_num    (pkt_num),
    .ipg        (ipg),
    .tx_mac_wa  (tx_mac_wa),
    .tx_mac_wr  (tx_mac_wr),
    .tx_mac_data(tx_mac_data),
    .tx_mac_be  (tx_mac_be),
    .tx_mac_sop (tx_mac_sop),
    .tx_mac_eop (tx_mac_eop),
    .busy       (busy),
    .done       (done),
    .pkt_cnt    (pkt_cnt),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk_user = ~clk_user;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte i of frame n is (n + i) mod 256; lanes past the frame end are zero.
  function automatic logic [DATA_W-1:0] exp_word(input int n, input int k, input int l);
    logic [DATA_W-1:0] v;
    int i;
    v = '0;
    for (int j = 0; j < BPW; j++) begin
      i = k * BPW + j;
      if (i < l) v[DATA_W-1-8*j -: 8] = 8'((n + i) % 256);
    end
    return v;
  endfunction

  // mode: 0 = wa always high, 1 = random wa, 2 = wa low 3 cycles at frame 0 word 7.
  // ab_frame/ab_word: abort while that word is pending (-1 = none).
  // ab_gap: abort this many cycles after the first eop (0 = none).
  task automatic run_burst(input int len, input int num, input int gap, input int mode,
                           input int ab_frame, input int ab_word, input int ab_gap,
                           input bit start_abort);
    int l, w, rem, n, k, cyc, last_eop, exp_frames, done_cyc, stall_left, bytes;
    bit prev_eop, ab_sent, poked, stalled, fin, wa_v;
    l          = (len > MAX_LEN) ? MAX_LEN : (len < MIN_LEN) ? MIN_LEN : len;
    w          = (l + BPW - 1) / BPW;
    rem        = l % BPW;
    exp_frames = (ab_gap > 0) ? 1 : (ab_frame >= 0) ? ab_frame + 1 : num;
    n = 0; k = 0; cyc = 0; last_eop = -1; done_cyc = -1; stall_left = 0; bytes = 0;
    prev_eop = 0; ab_sent = 0; poked = 0; stalled = 0; fin = 0;

    @(posedge clk_user); #1;
    start = 1'b1; abort = start_abort; tx_mac_wa = 1'b1;
    pkt_len = 11'(len); pkt_num = CNT_W'(num); ipg = 8'(gap);
    @(posedge clk_user); #1;
    while (!fin && cyc < 20000) begin
      start = 1'b0; abort = 1'b0;
      if (mode == 2 && !stalled && n == 0 && k == 7) begin stall_left = 3; stalled = 1; end
      if (mode == 1) wa_v = ($urandom_range(0, 3) != 0);
      else           wa_v = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      tx_mac_wa = wa_v;
      if (!ab_sent && ab_frame >= 0 && n == ab_frame && k == ab_word) begin
        abort = 1'b1; ab_sent = 1;
      end
      if (!ab_sent && ab_gap > 0 && last_eop >= 0 && cyc == last_eop + ab_gap) begin
        abort = 1'b1; ab_sent = 1; done_cyc = cyc + 1;
      end
      // A start while busy, with different parameters, must change nothing
      if (!poked && n == 0 && k == 2) begin
        start = 1'b1; poked = 1;
        pkt_len = 11'($urandom); pkt_num = CNT_W'($urandom); ipg = 8'($urandom);
      end
      @(negedge clk_user);
      if (prev_eop) begin
        check("pkt_cnt_after_eop", pkt_cnt, n);
        check("byte_cnt_after_eop", byte_cnt, bytes);
        prev_eop = 0;
      end
      if (!wa_v) check("wr_low_on_stall", tx_mac_wr, 0);
      if (mode == 2 && !wa_v) check("held_data", tx_mac_data, exp_word(0, 7, l));
      if (done) begin
        check("done_cycle", cyc, done_cyc);
        check("busy_at_done", busy, 0);
        check("final_pkt_cnt", pkt_cnt, exp_frames);
        check("final_byte_cnt", byte_cnt, exp_frames * l);
        fin = 1;
      end else if (tx_mac_wr) begin
        if (n >= exp_frames) begin
          check("extra_word", tx_mac_wr, 0);
        end else begin
          check("data", tx_mac_data, exp_word(n, k, l));
          check("be", tx_mac_be, (k == w - 1) ? rem : 0);
          check("sop", tx_mac_sop, k == 0);
          check("eop", tx_mac_eop, k == w - 1);
          if (k == 0 && n > 0 && mode != 1) check("ipg_idle_cycles", cyc - last_eop - 1, gap);
          bytes += (k == w - 1 && rem != 0) ? rem : BPW;
          k++;
          if (k == w) begin
            last_eop = cyc; n++; k = 0; prev_eop = 1;
            if (n == exp_frames && ab_gap == 0) done_cyc = cyc + 1;
          end
        end
      end
      cyc++;
      @(posedge clk_user); #1;
    end
    if (!fin) check("done_timeout", done, 1);
    start = 1'b0; abort = 1'b0; tx_mac_wa = 1'b1;
    @(negedge clk_user);
    check("done_is_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1; tx_mac_wa = 1'b1;
    repeat (3) @(posedge clk_user);
    @(negedge clk_user);
    check("rst_wr", tx_mac_wr, 0);
    check("rst_data", tx_mac_data, 0);
    check("rst_be", tx_mac_be, 0);
    check("rst_sop", tx_mac_sop, 0);
    check("rst_eop", tx_mac_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    @(posedge clk_user); #1;
    reset = 1'b0;

    // Abort while idle is ignored
    abort = 1'b1;
    @(posedge clk_user); #1;
    abort = 1'b0;
    @(negedge clk_user);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    run_burst(64,   1, 0, 0, -1, 0, 0, 0);  // single 64-byte frame
    run_burst(61,   1, 0, 0, -1, 0, 0, 0);  // partial eop word
    run_burst(64,   3, 5, 0, -1, 0, 0, 0);  // gapped multi-frame burst
    run_burst(64,   1, 0, 2, -1, 0, 0, 0);  // stall at word 7
    run_burst(10,   0, 0, 0,  0, 4, 0, 0);  // clamp up, continuous, abort mid-frame
    run_burst(2000, 1, 0, 0, -1, 0, 0, 0);  // clamp down to max length
    run_burst(64,   2, 1, 0, -1, 0, 0, 1);  // start and abort together
    run_burst(64,   0, 6, 0, -1, 0, 3, 0);  // abort during gap

    // Reset mid-frame while word 8 is presented
    @(posedge clk_user); #1;
    start = 1'b1; pkt_len = 11'd64; pkt_num = 16'd1; ipg = 8'd0; tx_mac_wa = 1'b1;
    @(posedge clk_user); #1;
    start = 1'b0;
    repeat (8) @(posedge clk_user);
    #1;
    reset = 1'b1;
    @(negedge clk_user);
    check("pre_reset_word8", tx_mac_data, 32'h20212223);
    @(posedge clk_user); #1;
    reset = 1'b0;
    @(negedge clk_user);
    check("mid_rst_wr", tx_mac_wr, 0);
    check("mid_rst_data", tx_mac_data, 0);
    check("mid_rst_eop", tx_mac_eop, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_byte_cnt", byte_cnt, 0);
    run_burst(64, 1, 0, 0, -1, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0)
        run_burst($urandom_range(0, 2047), $urandom_range(1, 3), $urandom_range(0, 4), 1,
                  -1, 0, 0, 0);
      else
        run_burst($urandom_range(0, 2047), 0, $urandom_range(0, 4), 1,
                  $urandom_range(0, 1), $urandom_range(1, 10), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
